// File: rtl/seq_muldiv.sv
// Sequential RISC-V M-extension unit: shift-add multiply, restoring divide.
// Ports: i_valid/o_ready request in; o_valid/i_ready result out; i_flush abort; o_busy.
module seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;

  logic                is_div, a_signed, b_signed;
  logic                sign_a, sign_b, div_zero, ovf;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     quo, rem, res;

  always_comb begin
    is_div   = i_op[2];
    a_signed = is_div ? ~i_op[0] : (i_op != 3'b011);
    b_signed = is_div ? ~i_op[0] : ~i_op[1];
    sign_a   = a_signed & i_operand_a[XLEN-1];
    sign_b   = b_signed & i_operand_b[XLEN-1];
    a_mag    = sign_a ? (0 - i_operand_a) : i_operand_a;
    b_mag    = sign_b ? (0 - i_operand_b) : i_operand_b;
    div_zero = is_div & (i_operand_b == '0);
    ovf      = is_div & ~i_op[0] & (i_operand_a == MIN_NEG)
             & (i_operand_b == '1);
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
              + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opb_q};
    if (div_trial[XLEN])
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod = (sa_q ^ sb_q) ? (0 - acc_q) : acc_q;
    quo  = (sa_q ^ sb_q) ? (0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem  = sa_q ? (0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      3'b000:  res = prod[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  res = prod[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  res = quo;
      default: res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          op_d = i_op;
          // Bypass cases preload acc so the normal selection yields the
          // architectural result with signs cleared.
          if (div_zero) begin
            acc_d   = {i_operand_a, {XLEN{1'b1}}};
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            cnt_d   = '0;
            state_d = DONE;
          end else if (ovf) begin
            acc_d   = {{XLEN{1'b0}}, i_operand_a};
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            sa_d    = sign_a;
            sb_d    = sign_b;
            cnt_d   = CW'(XLEN);
            acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            opb_d   = is_div ? b_mag : a_mag;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1))
          state_d = DONE;
      end
      DONE: begin
        if (i_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_busy   = (state_q != IDLE);
  assign o_result = o_valid ? res : '0;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv (XLEN=32).
// Checks latency, results, bypasses, backpressure, flush and reset.
module tb_seq_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = '0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic        o_busy;

  int checks = 0;
  int failures = 0;

  seq_muldiv #(.XLEN(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_operand_a (i_a),
    .i_operand_b (i_b),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_op    = 3'($urandom);
    i_a     = $urandom;
    i_b     = $urandom;
  endtask

  task automatic wait_valid(output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (o_valid) seen = 1'b1;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat_exp);
    int   lat;
    logic seen;
    issue(op, a, b);
    wait_valid(lat, seen);
    chk({tag, "_seen"}, 64'(seen), 64'(1));
    chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_res"}, 64'(o_result), 64'(exp));
    @(negedge clk);
    chk({tag, "_idle"}, {62'd0, o_ready, o_valid}, 64'b10);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic any_valid;

    #2;
    chk("rst_outs", {o_ready, o_valid, o_busy}, 3'b100);
    chk("rst_res", 64'(o_result), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("mul_7_m3",  3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulh",      3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
    run("mulhsu",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 33);
    run("mulhu",     3'b011, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h7FFF_FFFF, 33);
    run("mul_b0",    3'b000, 32'd5, 32'd0, 32'd0, 33);
    run("div",       3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem",       3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu",      3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    run("remu",      3'b111, 32'hFFFF_FFF9, 32'd2, 32'h1, 33);
    run("divu_z",    3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_z",     3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
    run("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1);
    run("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // backpressure
    i_ready = 1'b0;
    issue(3'b000, 32'h1234, 32'h10);
    wait_valid(lat, seen);
    chk("bp_seen", 64'(seen), 64'(1));
    chk("bp_res", 64'(o_result), 64'h12340);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {o_result, o_ready, o_valid, o_busy},
          {32'h12340, 3'b011});
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {o_ready, o_valid, o_busy}, 3'b100);

    // flush at step 10 of a DIV
    issue(3'b100, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    chk("fl_busy", {o_ready, o_busy}, 2'b01);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("fl_idle", {o_ready, o_valid, o_busy}, 3'b100);
    any_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      any_valid |= o_valid;
    end
    chk("fl_novalid", 64'(any_valid), 64'(0));

    // async reset mid-BUSY
    issue(3'b000, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {o_ready, o_valid, o_busy}, 3'b100);
    chk("arst_res", 64'(o_result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
